// File: rtl/tb_virt_periph_pkg.sv
// Shared definitions for the testbench virtual peripheral: register offsets,
// timer FSM state encoding and the default PASS magic word.
// Ports: none (package).
package tb_virt_periph_pkg;

  localparam logic [4:0] PRINT_OFF      = 5'h00;
  localparam logic [4:0] PASS_OFF       = 5'h04;
  localparam logic [4:0] FAIL_OFF       = 5'h08;
  localparam logic [4:0] EXIT_OFF       = 5'h0C;
  localparam logic [4:0] TIMER_VAL_OFF  = 5'h10;
  localparam logic [4:0] TIMER_CTRL_OFF = 5'h14;
  localparam logic [4:0] CYCLE_OFF      = 5'h18;
  localparam logic [4:0] RSVD_OFF       = 5'h1C;

  localparam logic [31:0] PASS_MAGIC_DEFAULT = 32'd123456789;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } timer_state_e;

endpackage

// File: rtl/tb_vp_timer.sv
// Countdown timer with level interrupt for the virtual peripheral.
// Ports: core_clk/core_rst_n; load + load_val (re)arm or stop the timer,
// ack clears a firing interrupt; count is the live value, irq the level output.
module tb_vp_timer
  import tb_virt_periph_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               core_clk,
  input  logic               core_rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               ack,
  output logic [TIMER_W-1:0] count,
  output logic               irq
);

  timer_state_e       state_q;
  logic [TIMER_W-1:0] count_q;

  // A load always wins, including on the cycle the count has just reached 0,
  // so a reload at that point suppresses the pending interrupt.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else if (load) begin
      if (load_val != '0) begin
        state_q <= COUNT;
        count_q <= load_val;
      end else begin
        state_q <= IDLE;
        count_q <= '0;
      end
    end else begin
      case (state_q)
        // The zero value is held for one cycle before firing, giving N+1
        // cycles from the load to the interrupt.
        COUNT: begin
          if (count_q == '0) state_q <= FIRE;
          else               count_q <= count_q - TIMER_W'(1);
        end
        FIRE: begin
          if (ack) state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign count = count_q;
  assign irq   = (state_q == FIRE);

endmodule

// File: rtl/tb_virt_periph_obi.sv
// OBI-attached virtual peripheral: console print, pass/fail/exit status,
// countdown timer interrupt and free-running cycle counter.
// Ports: OBI slave (req/gnt/addr/we/be/wdata, rvalid/rdata/err), print strobe
// and char, sticky test status, exit code, timer irq. Response 1 cycle after
// grant. Optional macro TB_VP_RANDOM_STALL_EN adds LFSR-driven grant stalls.
module tb_virt_periph_obi
  import tb_virt_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter logic [31:0] PASS_MAGIC = PASS_MAGIC_DEFAULT,
  parameter int          TIMER_W    = 32
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        print_valid_o,
  output logic [7:0]  print_char_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        timer_irq_o
);

`ifdef TB_VP_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic [1:0]  stall_run_q;
  logic        stall;

  // Stall run length saturates at 3 so the 4th cycle is always granted.
  assign stall = lfsr_q[0] && (stall_run_q != 2'd3);
  assign gnt_o = req_i && !stall;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      lfsr_q      <= 16'hACE1;
      stall_run_q <= 2'd0;
    end else begin
      // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
      lfsr_q      <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      stall_run_q <= stall ? stall_run_q + 2'd1 : 2'd0;
    end
  end
`else
  assign gnt_o = req_i;
`endif

  logic               accept;
  logic               in_win;
  logic [4:0]         off;
  logic               bad;
  logic [31:0]        rd_val;
  logic               wr_ok;
  logic [31:0]        cycle_q;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_load;
  logic               timer_ack;
  logic               addr_lsb_unused;

  assign accept          = req_i && gnt_o;
  assign in_win          = (addr_i[31:5] == BASE_ADDR[31:5]);
  assign off             = {addr_i[4:2], 2'b00};
  assign addr_lsb_unused = ^addr_i[1:0];

  // Decode: any illegal access is flagged here and suppresses all side effects.
  always_comb begin
    bad    = 1'b0;
    rd_val = '0;
    if (!in_win) begin
      bad = 1'b1;
    end else begin
      case (off)
        PRINT_OFF:                  bad = !we_i || !be_i[0];
        PASS_OFF, FAIL_OFF, EXIT_OFF: bad = !we_i || (be_i != 4'hF);
        TIMER_VAL_OFF: begin
          if (we_i) bad = (be_i != 4'hF);
          else      rd_val = 32'(timer_count);
        end
        TIMER_CTRL_OFF:             bad = !we_i;
        CYCLE_OFF: begin
          if (we_i) bad = 1'b1;
          else      rd_val = cycle_q;
        end
        default:                    bad = 1'b1;
      endcase
    end
  end

  assign wr_ok      = accept && we_i && !bad;
  assign timer_load = wr_ok && (off == TIMER_VAL_OFF);
  assign timer_ack  = wr_ok && (off == TIMER_CTRL_OFF) && wdata_i[0];

  tb_vp_timer #(.TIMER_W(TIMER_W)) u_timer (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .load       (timer_load),
    .load_val   (wdata_i[TIMER_W-1:0]),
    .ack        (timer_ack),
    .count      (timer_count),
    .irq        (timer_irq_o)
  );

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      rvalid_o       <= 1'b0;
      err_o          <= 1'b0;
      rdata_o        <= '0;
      print_valid_o  <= 1'b0;
      print_char_o   <= '0;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
      cycle_q        <= '0;
    end else begin
      cycle_q       <= cycle_q + 32'd1;
      rvalid_o      <= accept;
      err_o         <= accept && bad;
      rdata_o       <= (accept && !bad && !we_i) ? rd_val : 32'd0;
      print_valid_o <= wr_ok && (off == PRINT_OFF);
      if (wr_ok && (off == PRINT_OFF)) print_char_o <= wdata_i[7:0];
      if (wr_ok && (off == PASS_OFF)) begin
        if (wdata_i == PASS_MAGIC) tests_passed_o <= 1'b1;
        else                       tests_failed_o <= 1'b1;
      end
      if (wr_ok && (off == FAIL_OFF)) tests_failed_o <= 1'b1;
      if (wr_ok && (off == EXIT_OFF)) begin
        exit_valid_o <= 1'b1;
        exit_value_o <= wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_tb_virt_periph_obi.sv
// Self-checking bench for tb_virt_periph_obi: directed register scenarios plus
// randomized OBI accesses compared against a behavioural model of the map.
// Ports: none (top-level bench).
module tb_tb_virt_periph_obi;
  import tb_virt_periph_pkg::*;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic        core_clk = 1'b0;
  logic        core_rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        print_valid_o;
  logic [7:0]  print_char_o;
  logic        tests_passed_o;
  logic        tests_failed_o;
  logic        exit_valid_o;
  logic [31:0] exit_value_o;
  logic        timer_irq_o;

  tb_virt_periph_obi dut (
    .core_clk       (core_clk),
    .core_rst_n     (core_rst_n),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .addr_i         (addr_i),
    .we_i           (we_i),
    .be_i           (be_i),
    .wdata_i        (wdata_i),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .err_o          (err_o),
    .print_valid_o  (print_valid_o),
    .print_char_o   (print_char_o),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o),
    .timer_irq_o    (timer_irq_o)
  );

  always #5 core_clk = ~core_clk;

  // Reference cycle count: clock edges seen since reset release.
  int cyc;
  always @(posedge core_clk or negedge core_rst_n)
    if (!core_rst_n) cyc <= 0;
    else             cyc <= cyc + 1;

  // Behavioural model state
  bit          m_pass, m_fail, m_exit, m_armed;
  logic [31:0] m_exit_val;
  logic [7:0]  m_char;
  int          m_e;      // first cycle the loaded value is visible
  int          m_n;      // loaded value

  // Register access rules by word index 0..7
  bit rd_ok   [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
  bit wr_ok   [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
  bit full_be [8] = '{0, 1, 1, 1, 1, 0, 0, 0};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Timer behaviour as a function of time since the load
  function automatic bit irq_at(input int c);
    return m_armed && ((c - m_e) >= m_n + 1);
  endfunction

  function automatic logic [31:0] cnt_at(input int c);
    if (!m_armed || (c - m_e) > m_n) return 32'd0;
    return 32'(m_n - (c - m_e));
  endfunction

  task automatic model_clear();
    m_pass = 0; m_fail = 0; m_exit = 0; m_armed = 0;
    m_exit_val = '0; m_char = '0; m_e = 0; m_n = 0;
  endtask

  task automatic do_reset();
    @(negedge core_clk);
    core_rst_n = 1'b0;
    req_i = 1'b0;
    model_clear();
    repeat (2) @(negedge core_clk);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_print_valid", print_valid_o, 0);
    chk("rst_print_char", print_char_o, 0);
    chk("rst_pass", tests_passed_o, 0);
    chk("rst_fail", tests_failed_o, 0);
    chk("rst_exit_valid", exit_valid_o, 0);
    chk("rst_exit_value", exit_value_o, 0);
    chk("rst_irq", timer_irq_o, 0);
    core_rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge core_clk);
      chk("idle_rvalid", rvalid_o, 0);
      chk("idle_print_valid", print_valid_o, 0);
      chk("idle_irq", timer_irq_o, irq_at(cyc));
    end
  endtask

  task automatic access(input logic [31:0] a, input bit w, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd, output bit er);
    int          c0, waited, widx;
    bit          e, inwin, pv;
    logic [31:0] r;
    @(negedge core_clk);
    req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = d;
    #1;
    waited = 0;
    while (!gnt_o && waited < 16) begin
      @(negedge core_clk); #1; waited++;
    end
    if (!gnt_o) begin
      chk("gnt_timeout", 0, 1);
      req_i = 1'b0; rd = '0; er = 1'b0;
      return;
    end
    c0 = cyc;
    inwin = (a[31:5] == BASE[31:5]);
    widx = int'(a[4:2]);
    if (!inwin)  e = 1;
    else if (w)  e = !wr_ok[widx] || (full_be[widx] && b != 4'hF) || (widx == 0 && !b[0]);
    else         e = !rd_ok[widx];
    r = '0;
    if (!e && !w) r = (widx == 4) ? cnt_at(c0) : 32'(c0);
    pv = 0;
    if (!e && w) begin
      case (widx)
        0: begin m_char = d[7:0]; pv = 1; end
        1: if (d == MAGIC) m_pass = 1; else m_fail = 1;
        2: m_fail = 1;
        3: begin m_exit = 1; m_exit_val = d; end
        4: if (d != 0) begin m_armed = 1; m_e = c0 + 1; m_n = int'(d); end
           else m_armed = 0;
        5: if (d[0] && irq_at(c0)) m_armed = 0;
        default: ;
      endcase
    end
    @(posedge core_clk);
    #1 req_i = 1'b0; we_i = 1'b0;
    @(negedge core_clk);
    chk("rvalid", rvalid_o, 1);
    chk("err", err_o, e);
    chk("rdata", rdata_o, r);
    chk("pass", tests_passed_o, m_pass);
    chk("fail", tests_failed_o, m_fail);
    chk("exit_valid", exit_valid_o, m_exit);
    chk("exit_value", exit_value_o, m_exit_val);
    chk("print_valid", print_valid_o, pv);
    chk("print_char", print_char_o, m_char);
    chk("irq", timer_irq_o, irq_at(cyc));
    rd = rdata_o;
    er = err_o;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd1;
    bit er;
    int c0;
    model_clear();
    do_reset();

    // Print
    access(BASE + 32'h00, 1, 4'h1, 32'h0000_0048, rd, er);
    chk("print_char_48", print_char_o, 32'h48);
    @(negedge core_clk);
    chk("print_pulse_end", print_valid_o, 0);
    chk("print_char_held", print_char_o, 32'h48);

    // Pass magic, then wrong value after reset
    access(BASE + 32'h04, 1, 4'hF, MAGIC, rd, er);
    chk("pass_set", tests_passed_o, 1);
    chk("pass_no_fail", tests_failed_o, 0);
    do_reset();
    access(BASE + 32'h04, 1, 4'hF, 32'd5, rd, er);
    chk("pass_bad_fails", tests_failed_o, 1);

    // Exit twice
    access(BASE + 32'h0C, 1, 4'hF, 32'h2A, rd, er);
    chk("exit_val_2a", exit_value_o, 32'h2A);
    access(BASE + 32'h0C, 1, 4'hF, 32'h0, rd, er);
    chk("exit_val_0", exit_value_o, 32'h0);
    chk("exit_still_valid", exit_valid_o, 1);

    // Timer: fire, ack, reload at count 1
    access(BASE + 32'h10, 1, 4'hF, 32'd3, rd, er);
    idle(5);
    chk("irq_fired", timer_irq_o, 1);
    access(BASE + 32'h14, 1, 4'hF, 32'd1, rd, er);
    chk("irq_acked", timer_irq_o, 0);
    access(BASE + 32'h10, 1, 4'hF, 32'd3, rd, er);
    idle(1);
    access(BASE + 32'h10, 1, 4'hF, 32'd3, rd, er);
    idle(2);
    chk("irq_reload_quiet", timer_irq_o, 0);
    idle(3);
    chk("irq_reload_fired", timer_irq_o, 1);

    // Cycle counter reads 10 cycles apart; write is an error
    access(BASE + 32'h18, 0, 4'hF, 32'h0, rd, er);
    idle(8);
    access(BASE + 32'h18, 0, 4'hF, 32'h0, rd1, er);
    chk("cycle_delta", rd1 - rd, 32'd10);
    access(BASE + 32'h18, 1, 4'hF, 32'h1234, rd, er);
    chk("cycle_write_err", er, 1);

    // Error cases
    access(BASE + 32'h00, 0, 4'hF, 32'h0, rd, er);
    chk("rd_print_err", er, 1);
    access(32'h3000_0000, 0, 4'hF, 32'h0, rd, er);
    chk("out_of_window_err", er, 1);
    chk("out_of_window_rdata", rd, 0);
    access(BASE + 32'h0C, 1, 4'h3, 32'h77, rd, er);
    chk("exit_partial_err", er, 1);
    chk("exit_partial_keep", exit_value_o, 32'h0);
    access(BASE + 32'h1C, 0, 4'hF, 32'h0, rd, er);
    chk("reserved_err", er, 1);

    // Back-to-back reads give back-to-back responses
    @(negedge core_clk);
    req_i = 1'b1; addr_i = BASE + 32'h18; we_i = 1'b0; be_i = 4'hF;
    #1 c0 = cyc;
    chk("b2b_gnt", gnt_o, 1);
    @(posedge core_clk);
    @(negedge core_clk);
    chk("b2b_rvalid0", rvalid_o, 1);
    chk("b2b_rdata0", rdata_o, 32'(c0));
    @(posedge core_clk);
    #1 req_i = 1'b0;
    @(negedge core_clk);
    chk("b2b_rvalid1", rvalid_o, 1);
    chk("b2b_rdata1", rdata_o, 32'(c0 + 1));
    idle(1);

    // Randomized accesses against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int          sel;
      logic [31:0] a, d;
      logic [3:0]  b;
      bit          w;
      if (i == 150) do_reset();
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = BASE + 32'(sel * 4);
      else if (sel == 8) a = 32'h3000_0000 + 32'($urandom_range(0, 7) * 4);
      else               a = BASE + 32'h20;
      w = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      case (sel)
        1:       d = ($urandom_range(0, 3) == 0) ? MAGIC : $urandom;
        4:       d = $urandom_range(0, 12);
        5:       d = $urandom_range(0, 3);
        default: d = $urandom;
      endcase
      access(a, w, b, d, rd, er);
      idle($urandom_range(0, 3));
    end

    // Reset in the middle of an access drops the response and clears state
    @(negedge core_clk);
    req_i = 1'b1; addr_i = BASE + 32'h0C; we_i = 1'b1; be_i = 4'hF; wdata_i = 32'h55;
    @(posedge core_clk);
    #2 core_rst_n = 1'b0;
    req_i = 1'b0;
    #1;
    chk("midrst_rvalid", rvalid_o, 0);
    chk("midrst_exit_valid", exit_valid_o, 0);
    chk("midrst_exit_value", exit_value_o, 0);
    chk("midrst_irq", timer_irq_o, 0);
    @(negedge core_clk);
    core_rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tb_virt_periph_obi.md
Name: tb_virt_periph_obi

Overview:
Memory-mapped virtual peripheral on the core's OBI data port in the core testbench wrapper. It is the producing end of the end-of-test status signals sampled by the testbench top: tests_passed, tests_failed, exit_valid and exit_value. Firmware stores to fixed addresses to print characters, signal pass/fail/exit, and program a countdown timer interrupt. A free-running cycle counter is readable.

Parameters:
BASE_ADDR, 32'h2000_0000, base of the 32-byte peripheral window; the address decode compares addr_i[31:5].
PASS_MAGIC, 32'd123456789, value that must be written to the PASS register to assert pass.
TIMER_W, 32, width of the timer down-counter.

Ports:
core_clk  in  1  clock
core_rst_n  in  1  reset, asynchronous, active-low
req_i  in  1  OBI request
gnt_o  out  1  OBI grant
addr_i  in  32  byte address
we_i  in  1  1 = write
be_i  in  4  byte enables
wdata_i  in  32  write data
rvalid_o  out  1  response valid
rdata_o  out  32  read data
err_o  out  1  response error, qualified by rvalid_o
print_valid_o  out  1  one-cycle strobe: character written
print_char_o  out  8  character
tests_passed_o  out  1  sticky pass
tests_failed_o  out  1  sticky fail
exit_valid_o  out  1  sticky exit
exit_value_o  out  32  exit code
timer_irq_o  out  1  timer interrupt, level

Behaviour:
- Reset values: all outputs 0. Timer FSM in IDLE. Cycle counter 0.
- Register map (offsets from BASE_ADDR):
  - 0x00 PRINT: write-only. Requires be_i[0]. Data is wdata_i[7:0].
  - 0x04 PASS: write-only.
  - 0x08 FAIL: write-only.
  - 0x0C EXIT: write-only.
  - 0x10 TIMER_VAL: read/write.
  - 0x14 TIMER_CTRL: write-only. Bit0 = irq ack.
  - 0x18 CYCLE: read-only.
  - 0x1C: reserved.
- Handshake:
  - gnt_o = req_i, combinational, with no stall when the optional feature is absent.
  - The access is accepted on a cycle where req_i && gnt_o.
  - rvalid_o is asserted exactly one cycle after acceptance, for reads and writes.
  - Back-to-back accesses give back-to-back rvalid_o.
- err_o=1 with rvalid_o in any of these cases; the access then has no side effect:
  - address outside the window;
  - offset 0x1C;
  - write to CYCLE;
  - read of a write-only register;
  - write to PASS, FAIL, EXIT or TIMER_VAL with be_i != 4'hF.
- rdata_o:
  - 0 on errors and on writes;
  - on reads, the value registered at acceptance (TIMER_VAL returns the live count at that cycle).
- PRINT: print_valid_o pulses for 1 cycle, one cycle after acceptance; print_char_o is held until the next print.
- PASS:
  - wdata == PASS_MAGIC: sets tests_passed_o.
  - Any other value: sets tests_failed_o.
- FAIL: any write sets tests_failed_o.
- EXIT: sets exit_valid_o and latches exit_value_o = wdata_i. A second EXIT write updates exit_value_o.
- PASS, FAIL and EXIT flags are sticky until reset. They take effect in the same cycle as rvalid_o.
- Cycle counter:
  - increments every cycle out of reset;
  - wraps 0xFFFF_FFFF -> 0;
  - a read returns the value at acceptance.
- Timer FSM states: IDLE, COUNT, FIRE.
  - Write TIMER_VAL=N, N != 0, from any state: load N, clear irq, go to COUNT.
  - Write TIMER_VAL=0: go to IDLE, irq cleared.
  - COUNT: decrement each cycle. On the cycle the count reaches 0, go to FIRE. The irq therefore asserts N+1 cycles after the write's acceptance edge.
  - FIRE: timer_irq_o=1, held.
  - Write TIMER_CTRL with bit0=1 in FIRE: go to IDLE and drop irq next cycle. In other states this write is ignored.
  - A TIMER_VAL write in the same cycle that COUNT reaches 0: the reload wins and no irq is raised.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). A pending rvalid_o is dropped.

Optional Feature:
Macro TB_VP_RANDOM_STALL_EN.
- Defined:
  - gnt_o = req_i && !stall, where stall is bit0 of a 16-bit LFSR, seed 16'hACE1, polynomial x^16+x^14+x^13+x^11+1, advanced every cycle.
  - A stall never exceeds 3 consecutive cycles; a saturating counter forces a grant on the 4th cycle.
  - The master must hold req_i and its payload until granted.
- Undefined: gnt_o = req_i, and the LFSR logic is absent.

Decomposition:
- Package tb_virt_periph_pkg holds:
  - the offset localparams (PRINT_OFF … CYCLE_OFF);
  - the timer_state_e enum {IDLE, COUNT, FIRE};
  - the default PASS_MAGIC.
- Sub-module tb_vp_timer contains the timer FSM and down-counter. Its interface:
  - in: load, load_val, ack;
  - out: count, irq.

Test Plan:
- Write 0x48 to BASE+0x00 with be=4'h1 -> rvalid next cycle, err=0; print_valid_o 1-cycle pulse, print_char_o=0x48.
- Write 123456789 to BASE+0x04 -> tests_passed_o=1 with rvalid, tests_failed_o=0. After reset, write 5 to BASE+0x04 -> tests_failed_o=1.
- Write 0x2A to BASE+0x0C, then 0 -> exit_valid_o=1; exit_value_o=0x2A, then 0.
- Write 3 to BASE+0x10 -> timer_irq_o rises 4 cycles after acceptance. Write 1 to BASE+0x14 -> irq low next cycle. Rewrite 3 at count=1 -> no irq until 4 cycles after the rewrite.
- Read BASE+0x18 at two acceptances 10 cycles apart -> rdata differs by 10. Write BASE+0x18 -> err_o=1.
- Read BASE+0x00 or 0x3000_0000, or write BASE+0x0C with be=4'h3 -> err_o=1, rdata 0, exit_valid_o unchanged. With TB_VP_RANDOM_STALL_EN: 1000 random accesses -> no grant gap >3 cycles, all responses in order.
